// File: rtl/lpif_rx_pkg.sv
// Shared types for the LPIF RX strobe-lock block: lock-state encoding and interval width.
package lpif_rx_pkg;

  localparam int unsigned STB_IVAL_W = 8;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_LOCKED = 2'b10
  } lpif_rx_lock_st_t;

endpackage

// File: rtl/lpif_rx_stb_fsm.sv
// Strobe lock FSM: tracks strobe phase against the latched interval, counts good strobes to lock
// and bad events to drop lock. Flags one bad event per cycle for the optional error counter.
module lpif_rx_stb_fsm
  import lpif_rx_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr,
  input  logic                  rx_en,
  input  logic                  all_stb,
  input  logic                  any_stb,
  input  logic [STB_IVAL_W-1:0] stb_interval,
  output lpif_rx_lock_st_t      state,
  output logic                  skew_pulse,
  output logic                  bad_evt
);

  logic [STB_IVAL_W-1:0] ival, icnt, icnt_next, ival_new;
  logic [15:0]           good_cnt, miss_cnt;
  logic                  tracking, exp_stb, skew, good, bad;

  always_comb begin
    skew      = any_stb & ~all_stb;
    tracking  = (state == ST_CHECK) || (state == ST_LOCKED);
    exp_stb   = tracking && (icnt == '0);
    good      = exp_stb & all_stb;
    // Skew alongside a missing expected strobe is still a single bad event.
    bad       = (exp_stb & ~all_stb) | (~exp_stb & any_stb) | skew;
    icnt_next = (icnt == ival - STB_IVAL_W'(1)) ? '0 : icnt + STB_IVAL_W'(1);
    ival_new  = (stb_interval == '0) ? STB_IVAL_W'(1) : stb_interval;
    bad_evt   = rx_en & ((tracking & bad) | ((state == ST_HUNT) & skew));
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr || !rx_en) begin
      state      <= ST_HUNT;
      ival       <= '0;
      icnt       <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      skew_pulse <= 1'b0;
    end else begin
      skew_pulse <= skew;
      case (state)
        ST_HUNT: begin
          if (all_stb) begin
            ival     <= ival_new;
            icnt     <= (ival_new == STB_IVAL_W'(1)) ? '0 : STB_IVAL_W'(1);
            good_cnt <= 16'd1;
            miss_cnt <= '0;
            state    <= (LOCK_CNT == 1) ? ST_LOCKED : ST_CHECK;
          end
        end
        ST_CHECK: begin
          icnt <= icnt_next;
          if (bad) begin
            state    <= ST_HUNT;
            ival     <= '0;
            icnt     <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
          end else if (good) begin
            good_cnt <= good_cnt + 16'd1;
            if (good_cnt + 16'd1 == 16'(LOCK_CNT)) state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          icnt <= icnt_next;
          if (good) begin
            miss_cnt <= '0;
          end else if (bad) begin
            if (miss_cnt + 16'd1 == 16'(MISS_LIMIT)) begin
              state    <= ST_HUNT;
              ival     <= '0;
              icnt     <= '0;
              good_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + 16'd1;
            end
          end
        end
        default: begin
          state    <= ST_HUNT;
          ival     <= '0;
          icnt     <= '0;
          good_cnt <= '0;
          miss_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lpif_rx_stb_lock.sv
// LPIF RX strobe lock: 2-stage data pipeline, per-channel strobe reduction and lock FSM.
// Optional saturating bad-event counter enabled by LPIF_RX_STB_ERR_CNT_EN.
module lpif_rx_stb_lock
  import lpif_rx_pkg::*;
#(
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned PHY_WIDTH  = 80,
  parameter int unsigned STB_BIT    = 1,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic                        clk_wr,
  input  logic                        rst_wr,
  input  logic                        rx_en,
  input  logic [STB_IVAL_W-1:0]       stb_interval,
  input  logic [NUM_CH*PHY_WIDTH-1:0] rx_phy_in,
  output logic [NUM_CH*PHY_WIDTH-1:0] rx_data,
  output logic                        rx_data_vld,
  output logic                        rx_online_det,
  output logic [1:0]                  lock_state,
  output logic                        stb_skew_err,
  output logic [15:0]                 stb_err_cnt
);

  localparam int unsigned W = NUM_CH * PHY_WIDTH;

  logic [W-1:0]      rx_q;
  logic [NUM_CH-1:0] stb_vec;
  logic              all_stb, any_stb, bad_evt;
  lpif_rx_lock_st_t  state;

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      rx_q    <= '0;
      rx_data <= '0;
    end else begin
      rx_q    <= rx_phy_in;
      rx_data <= rx_q;
    end
  end

  always_comb begin
    stb_vec = '0;
    for (int i = 0; i < int'(NUM_CH); i++) stb_vec[i] = rx_q[i*PHY_WIDTH + STB_BIT];
    all_stb = &stb_vec;
    any_stb = |stb_vec;
  end

  lpif_rx_stb_fsm #(
    .LOCK_CNT  (LOCK_CNT),
    .MISS_LIMIT(MISS_LIMIT)
  ) u_fsm (
    .clk_wr      (clk_wr),
    .rst_wr      (rst_wr),
    .rx_en       (rx_en),
    .all_stb     (all_stb),
    .any_stb     (any_stb),
    .stb_interval(stb_interval),
    .state       (state),
    .skew_pulse  (stb_skew_err),
    .bad_evt     (bad_evt)
  );

  // State updates on the same edge as rx_data, so validity lines up with the data word.
  assign lock_state    = state;
  assign rx_online_det = (state == ST_LOCKED);
  assign rx_data_vld   = rx_online_det;

`ifdef LPIF_RX_STB_ERR_CNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      err_cnt <= '0;
    end else if (bad_evt && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign stb_err_cnt = err_cnt;
`else
  logic unused_bad_evt;
  assign unused_bad_evt = bad_evt;
  assign stb_err_cnt    = '0;
`endif

endmodule
